audio_level_meter: RTL and testbench

- Multi-channel successor to the single-channel energy visualiser.
- Each channel has a sliding-window mean-square meter and a peak-hold/decay meter. Both run continuously.
- Each channel drives a BAR_W-bit thermometer bar; `mode` selects which meter drives it.
- Sits between the audio sample source (I2S/PCM decoder) and the LED/display driver.
- Adds a valid qualifier, a synchronous reset with a buffer-clear sweep, and a peak mode.

---
 rtl/audio_viz_pkg.sv | 27 ++
 rtl/audio_energy_window.sv | 83 ++++++++
 rtl/audio_level_meter.sv | 138 +++++++++++++
 tb/tb_audio_level_meter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/audio_viz_pkg.sv
// Shared types and width/threshold helpers for the multi-channel audio level meter.
package audio_viz_pkg;

    typedef enum logic {CLEAR, RUN} meter_state_t;

    function automatic int sq_width(input int sample_w);
        return 2 * sample_w - 1;
    endfunction

    function automatic int acc_width(input int sample_w, input int log2_win);
        return sq_width(sample_w) + log2_win;
    endfunction

    // Magnitude reaches 2^(sample_w-1), so it needs the full sample width.
    function automatic int peak_width(input int sample_w);
        return sample_w;
    endfunction

    function automatic longint unsigned ms_threshold(input int k, input int sample_w, input int bar_w);
        return 64'd1 << (2 * (sample_w - 1) - 2 * (bar_w - 1 - k));
    endfunction

    function automatic longint unsigned pk_threshold(input int k, input int sample_w, input int bar_w);
        return 64'd1 << (sample_w - 1 - (bar_w - 1 - k));
    endfunction

endpackage

// File: rtl/audio_energy_window.sv
// One channel: square stage, peak-hold/decay, ring buffer of squares and the sliding-window sum.
module audio_energy_window
    import audio_viz_pkg::*;
#(
    parameter int SAMPLE_W  = 8,
    parameter int LOG2_WIN  = 12,
    parameter int PEAK_HOLD = 4800,
    localparam int SQ_W     = sq_width(SAMPLE_W),
    localparam int ACC_W    = acc_width(SAMPLE_W, LOG2_WIN),
    localparam int PK_W     = peak_width(SAMPLE_W)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                s1_valid,
    input  logic                s2_valid,
    input  logic [LOG2_WIN-1:0] wr_addr,
    input  logic [LOG2_WIN-1:0] rd_addr,
    input  logic [SAMPLE_W-1:0] m,
    output logic [ACC_W-1:0]    acc,
    output logic [PK_W-1:0]     peak
);

    localparam int DEPTH  = 1 << LOG2_WIN;
    localparam int HOLD_W = $clog2(PEAK_HOLD + 1);
    localparam int PAD    = SQ_W - SAMPLE_W;

    logic [SQ_W-1:0]   buffer [DEPTH];
    logic [SQ_W-1:0]   rd_data_reg;
    logic [SQ_W-1:0]   sq_reg;
    logic [SQ_W-1:0]   m_wide;
    logic [SQ_W-1:0]   sq_next;
    logic [ACC_W-1:0]  acc_reg;
    logic [PK_W-1:0]   peak_reg;
    logic [PK_W-1:0]   peak_s3_reg;
    logic [HOLD_W-1:0] hold_reg;

    // |d|^2 equals d^2, so the unsigned magnitude is enough to form the square.
    assign m_wide  = {{PAD{1'b0}}, m};
    assign sq_next = m_wide * m_wide;

    // The read address is issued one stage early (head already advanced for a sample
    // leaving S3), so the oldest square is registered in time for the S3 update.
    always_ff @(posedge clk) begin
        if (clear) begin
            buffer[wr_addr] <= '0;
        end else if (s2_valid) begin
            buffer[wr_addr] <= sq_reg;
        end
        rd_data_reg <= buffer[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sq_reg      <= '0;
            peak_reg    <= '0;
            hold_reg    <= '0;
            acc_reg     <= '0;
            peak_s3_reg <= '0;
        end else begin
            if (s1_valid) begin
                sq_reg <= sq_next;
                if (m >= peak_reg) begin
                    peak_reg <= m;
                    hold_reg <= HOLD_W'(PEAK_HOLD);
                end else if (hold_reg != '0) begin
                    hold_reg <= hold_reg - HOLD_W'(1);
                end else if (peak_reg != '0) begin
                    peak_reg <= peak_reg - PK_W'(1);
                end
            end
            // Peak is re-registered here so both meters describe the same sample at S4.
            if (s2_valid) begin
                acc_reg     <= acc_reg - ACC_W'(rd_data_reg) + ACC_W'(sq_reg);
                peak_s3_reg <= peak_reg;
            end
        end
    end

    assign acc  = acc_reg;
    assign peak = peak_s3_reg;

endmodule

// File: rtl/audio_level_meter.sv
// Multi-channel mean-square / peak level meter with buffer-clear sweep and thermometer bar outputs.
module audio_level_meter
    import audio_viz_pkg::*;
#(
    parameter int SAMPLE_W  = 8,
    parameter int LOG2_WIN  = 12,
    parameter int CHANNELS  = 2,
    parameter int BAR_W     = 8,
    parameter int PEAK_HOLD = 4800
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         mode,
    input  logic                         sample_valid,
    input  logic [CHANNELS*SAMPLE_W-1:0] sample_in,
    output logic                         busy,
    output logic                         level_valid,
    output logic [CHANNELS*BAR_W-1:0]    bar_out
);

    localparam int SQ_W  = sq_width(SAMPLE_W);
    localparam int ACC_W = acc_width(SAMPLE_W, LOG2_WIN);
    localparam int PK_W  = peak_width(SAMPLE_W);
    localparam logic [SAMPLE_W-1:0] CENTRE   = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic [LOG2_WIN-1:0] HEAD_ONE = {{(LOG2_WIN-1){1'b0}}, 1'b1};

    meter_state_t              state_reg;
    logic [LOG2_WIN-1:0]       head_reg;
    logic [LOG2_WIN-1:0]       rd_addr;
    logic                      busy_reg;
    logic                      accept;
    logic                      v1_reg, v2_reg, v3_reg;
    logic                      level_valid_reg;
    logic [CHANNELS*BAR_W-1:0] bar_reg;
    logic [CHANNELS*BAR_W-1:0] bar_next;

    assign accept = (state_reg == RUN) && sample_valid;
    assign rd_addr = head_reg + {{(LOG2_WIN-1){1'b0}}, v2_reg};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= CLEAR;
            head_reg  <= '0;
            busy_reg  <= 1'b1;
        end else if (state_reg == CLEAR) begin
            head_reg <= head_reg + HEAD_ONE;
            if (head_reg == '1) begin
                state_reg <= RUN;
                busy_reg  <= 1'b0;
            end
        end else if (v2_reg) begin
            head_reg <= head_reg + HEAD_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_reg <= 1'b0;
            v2_reg <= 1'b0;
            v3_reg <= 1'b0;
        end else begin
            v1_reg <= accept;
            v2_reg <= v1_reg;
            v3_reg <= v2_reg;
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic [SAMPLE_W-1:0] s;
        logic [SAMPLE_W-1:0] m_next;
        logic [SAMPLE_W-1:0] m_reg;
        logic [ACC_W-1:0]    acc;
        logic [SQ_W-1:0]     mean;
        logic [PK_W-1:0]     peak;
        logic [BAR_W-1:0]    ms_bar;
        logic [BAR_W-1:0]    pk_bar;

        // Offset-binary distance from centre without forming the signed value.
        assign s      = sample_in[gi*SAMPLE_W +: SAMPLE_W];
        assign m_next = s[SAMPLE_W-1] ? {1'b0, s[SAMPLE_W-2:0]} : CENTRE - s;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                m_reg <= '0;
            end else if (accept) begin
                m_reg <= m_next;
            end
        end

        audio_energy_window #(
            .SAMPLE_W  (SAMPLE_W),
            .LOG2_WIN  (LOG2_WIN),
            .PEAK_HOLD (PEAK_HOLD)
        ) u_win (
            .clk      (clk),
            .rst_n    (rst_n),
            .clear    (state_reg == CLEAR),
            .s1_valid (v1_reg),
            .s2_valid (v2_reg),
            .wr_addr  (head_reg),
            .rd_addr  (rd_addr),
            .m        (m_reg),
            .acc      (acc),
            .peak     (peak)
        );

        assign mean = SQ_W'(acc >> LOG2_WIN);

        for (genvar gj = 0; gj < BAR_W; gj++) begin : g_seg
            localparam logic [SQ_W-1:0] MS_TH = SQ_W'(ms_threshold(gj, SAMPLE_W, BAR_W));
            localparam logic [PK_W-1:0] PK_TH = PK_W'(pk_threshold(gj, SAMPLE_W, BAR_W));
            assign ms_bar[gj] = (mean >= MS_TH);
            assign pk_bar[gj] = (peak >= PK_TH);
        end

        assign bar_next[gi*BAR_W +: BAR_W] = mode ? pk_bar : ms_bar;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_valid_reg <= 1'b0;
            bar_reg         <= '0;
        end else begin
            level_valid_reg <= v3_reg & en;
            if (!en) begin
                bar_reg <= '0;
            end else if (v3_reg) begin
                bar_reg <= bar_next;
            end
        end
    end

    assign busy        = busy_reg;
    assign level_valid = level_valid_reg;
    assign bar_out     = bar_reg;

endmodule

// File: tb/tb_audio_level_meter.sv
// Scoreboard bench for audio_level_meter: a reference model pushes expected bars, the monitor pops on level_valid.
module tb_audio_level_meter;

    localparam int NCH   = 2;
    localparam int DEPTH = 4096;
    localparam int HOLD  = 4800;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic        mode = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_in = '0;
    logic        busy;
    logic        level_valid;
    logic [15:0] bar_out;

    audio_level_meter #(
        .SAMPLE_W  (8),
        .LOG2_WIN  (12),
        .CHANNELS  (NCH),
        .BAR_W     (8),
        .PEAK_HOLD (HOLD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .mode         (mode),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .busy         (busy),
        .level_valid  (level_valid),
        .bar_out      (bar_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] bar;
        int          cyc;
    } exp_t;

    exp_t   sb[$];
    int     total = 0;
    int     bad = 0;
    int     cyc = 0;
    int     lv_seen = 0;
    int     mbuf [NCH][DEPTH];
    longint macc [NCH];
    int     mpeak [NCH];
    int     mhold [NCH];
    int     mhead;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, expv);
        end
    endtask

    function automatic logic [7:0] ms_bar_model(input longint mean);
        logic [7:0] b;
        for (int k = 0; k < 8; k++) b[k] = (mean >= (longint'(1) << (2 * k)));
        return b;
    endfunction

    function automatic logic [7:0] pk_bar_model(input int p);
        logic [7:0] b;
        for (int k = 0; k < 8; k++) b[k] = (p >= (1 << k));
        return b;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            for (int i = 0; i < DEPTH; i++) mbuf[c][i] = 0;
            macc[c]  = 0;
            mpeak[c] = 0;
            mhold[c] = 0;
        end
        mhead = 0;
    endtask

    always @(negedge clk) begin
        if (level_valid === 1'b1) begin
            exp_t e;
            lv_seen++;
            if (sb.size() == 0) begin
                check_val("spurious_level_valid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                $display("txn bar=%h exp=%h latency=%0d", bar_out, e.bar, cyc - e.cyc);
                check_val("bar", {16'h0, bar_out}, {16'h0, e.bar});
                check_val("latency", cyc - e.cyc, 32'd4);
            end
        end
    end

    task automatic send(input logic [7:0] s0, input logic [7:0] s1);
        logic [15:0] e;
        @(negedge clk);
        sample_valid = 1'b1;
        sample_in    = {s1, s0};
        if (busy === 1'b0) begin
            e = '0;
            for (int c = 0; c < NCH; c++) begin
                int s, d, m, sq;
                s  = (c == 0) ? int'(s0) : int'(s1);
                d  = s - 128;
                m  = (d < 0) ? -d : d;
                sq = d * d;
                if (m >= mpeak[c]) begin
                    mpeak[c] = m;
                    mhold[c] = HOLD;
                end else if (mhold[c] != 0) begin
                    mhold[c]--;
                end else if (mpeak[c] != 0) begin
                    mpeak[c]--;
                end
                macc[c] += longint'(sq) - longint'(mbuf[c][mhead]);
                mbuf[c][mhead] = sq;
                e[c*8 +: 8] = mode ? pk_bar_model(mpeak[c]) : ms_bar_model(macc[c] >>> 12);
            end
            mhead = (mhead + 1) % DEPTH;
            if (en) sb.push_back('{bar: e, cyc: cyc});
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            sample_valid = 1'b0;
        end
    endtask

    task automatic do_reset(input bit drive_during);
        int n;
        int lv0;
        @(negedge clk);
        rst_n = 1'b0;
        sample_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        model_reset();
        check_val("reset_bar", {16'h0, bar_out}, 32'h0);
        check_val("reset_busy", {31'h0, busy}, 32'd1);
        check_val("reset_lv", {31'h0, level_valid}, 32'd0);
        lv0 = lv_seen;
        n = 0;
        sample_valid = drive_during;
        sample_in    = 16'h0000;
        while (busy === 1'b1 && n < 5000) begin
            n++;
            @(negedge clk);
        end
        sample_valid = 1'b0;
        check_val("clear_len", n, 32'd4096);
        check_val("lv_in_clear", lv_seen - lv0, 32'd0);
        check_val("bar_after_clear", {16'h0, bar_out}, 32'h0);
    endtask

    initial begin
        int lv0;
        repeat (2) @(negedge clk);

        do_reset(1'b1);

        for (int i = 0; i < DEPTH; i++) send(8'h80, 8'h80);
        idle(8);
        check_val("silence_drain", sb.size(), 32'd0);
        check_val("silence_bar", {16'h0, bar_out}, 32'h0);

        do_reset(1'b0);
        send(8'h00, 8'h80);
        idle(8);
        check_val("single_fs_bar", {16'h0, bar_out}, 32'h0003);

        do_reset(1'b0);
        for (int i = 0; i < DEPTH; i++) send(8'h00, 8'h90);
        idle(8);
        check_val("full_window_bar", {16'h0, bar_out}, 32'h1FFF);

        do_reset(1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            send(8'h00, 8'h90);
            idle($urandom_range(0, 5));
        end
        idle(8);
        check_val("gapped_window_bar", {16'h0, bar_out}, 32'h1FFF);
        check_val("gapped_drain", sb.size(), 32'd0);

        do_reset(1'b0);
        mode = 1'b1;
        send(8'h00, 8'h80);
        for (int i = 0; i < HOLD + 64; i++) send(8'h80, 8'h80);
        idle(8);
        check_val("peak_decay_bar", {16'h0, bar_out}, 32'h007F);
        mode = 1'b0;

        en  = 1'b0;
        lv0 = lv_seen;
        send(8'h00, 8'h80);
        send(8'h00, 8'h80);
        idle(8);
        check_val("en_low_lv", lv_seen - lv0, 32'd0);
        check_val("en_low_bar", {16'h0, bar_out}, 32'h0);
        en = 1'b1;
        send(8'h80, 8'h80);
        idle(8);
        check_val("en_resume_bar", {16'h0, bar_out}, 32'h0003);

        for (int i = 0; i < 20; i++) send(8'h00, 8'h80);
        do_reset(1'b0);
        send(8'h00, 8'h80);
        idle(8);
        check_val("post_reset_fresh", {16'h0, bar_out}, 32'h0003);
        check_val("final_drain", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        bad++;
        $display("FAIL watchdog got=timeout expected=completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
